// File: rtl/nested_loop_counter.sv
`default_nettype none
// ============================================================================
// Module   : nested_loop_counter
// Brief    : Programmable NLEVELS-deep nested index counter with start/busy/done
//            handshake, per-level last-step flags and optional auto-restart.
// Revision : 1.0
// ============================================================================
module nested_loop_counter #(
    parameter int WIDTH   = 13,
    parameter int NLEVELS = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       en,
    input  logic                       auto_restart,
    input  logic [NLEVELS*WIDTH-1:0]   bound,
    output logic [NLEVELS*WIDTH-1:0]   idx,
    output logic                       busy,
    output logic [NLEVELS-1:0]         wrap,
    output logic                       done
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                           r_state;
    state_t                           w_state_nxt;
    logic [NLEVELS-1:0][WIDTH-1:0]    r_idx;
    logic [NLEVELS-1:0][WIDTH-1:0]    w_idx_nxt;
    logic [NLEVELS-1:0][WIDTH-1:0]    r_bnd;
    logic [NLEVELS-1:0][WIDTH-1:0]    w_bnd_nxt;
    logic [NLEVELS-1:0][WIDTH-1:0]    w_step_idx;
    logic [NLEVELS-1:0]               w_eq;
    logic [NLEVELS-1:0]               w_all;
    logic                             r_done;
    logic                             w_done_nxt;

    // w_all[k]: every level 0..k sits at its bound, i.e. level k wraps on a step.
    for (genvar k = 0; k < NLEVELS; k++) begin : g_level
        assign w_eq[k] = (r_idx[k] == r_bnd[k]);
        if (k == 0) begin : g_inner
            assign w_all[k]      = w_eq[k];
            assign w_step_idx[k] = w_all[k] ? '0 : r_idx[k] + WIDTH'(1);
        end else begin : g_outer
            assign w_all[k]      = w_all[k-1] & w_eq[k];
            assign w_step_idx[k] = w_all[k]   ? '0 :
                                   w_all[k-1] ? r_idx[k] + WIDTH'(1) : r_idx[k];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_bnd_nxt   = r_bnd;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_bnd_nxt   = bound;
                    w_idx_nxt   = '0;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (en) begin
                    w_idx_nxt = w_step_idx;
                    if (w_all[NLEVELS-1]) begin
                        w_done_nxt = 1'b1;
                        if (auto_restart) begin
                            w_bnd_nxt = bound;
                        end else begin
                            w_state_nxt = ST_IDLE;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_bnd   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_bnd   <= w_bnd_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign idx  = r_idx;
    assign busy = (r_state == ST_RUN);
    assign done = r_done;
    assign wrap = w_all & {NLEVELS{busy & en}};

endmodule
`default_nettype wire

// File: tb/tb_nested_loop_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_nested_loop_counter
// Brief    : Directed and randomized stimulus against a step-count reference
//            model of the nested loop counter (WIDTH=4, NLEVELS=2).
// Revision : 1.0
// ============================================================================
module tb_nested_loop_counter;

    localparam int WIDTH   = 4;
    localparam int NLEVELS = 2;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      start;
    logic                      en;
    logic                      auto_restart;
    logic [NLEVELS*WIDTH-1:0]  bound;
    logic [NLEVELS*WIDTH-1:0]  idx;
    logic                      busy;
    logic [NLEVELS-1:0]        wrap;
    logic                      done;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: a run is a flat step number decomposed in mixed radix.
    bit m_busy = 1'b0;
    bit m_done = 1'b0;
    int m_n    = 0;
    int m_b0   = 0;
    int m_b1   = 0;

    nested_loop_counter #(
        .WIDTH   (WIDTH),
        .NLEVELS (NLEVELS)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .en           (en),
        .auto_restart (auto_restart),
        .bound        (bound),
        .idx          (idx),
        .busy         (busy),
        .wrap         (wrap),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs, advance the model.
    task automatic cyc(input bit r, input bit s, input bit e, input bit a,
                       input int b1, input int b0);
        int total, e_i0, e_i1;
        bit e_w0, e_w1;
        @(negedge clk);
        rst          = r;
        start        = s;
        en           = e;
        auto_restart = a;
        bound        = {WIDTH'(b1), WIDTH'(b0)};
        #1;
        total = (m_b0 + 1) * (m_b1 + 1);
        e_i0  = m_busy ? m_n % (m_b0 + 1) : 0;
        e_i1  = m_busy ? (m_n / (m_b0 + 1)) % (m_b1 + 1) : 0;
        e_w0  = m_busy && e && (e_i0 == m_b0);
        e_w1  = m_busy && e && (m_n == total - 1);
        check("idx0", 32'(idx[WIDTH-1:0]),     32'(e_i0));
        check("idx1", 32'(idx[2*WIDTH-1:WIDTH]), 32'(e_i1));
        check("busy", 32'(busy),                32'(m_busy));
        check("done", 32'(done),                32'(m_done));
        check("wrap", 32'(wrap),                32'({e_w1, e_w0}));
        if (r) begin
            m_busy = 0; m_done = 0; m_n = 0; m_b0 = 0; m_b1 = 0;
        end else begin
            m_done = 0;
            if (!m_busy) begin
                if (s) begin
                    m_busy = 1; m_n = 0; m_b0 = b0; m_b1 = b1;
                end
            end else if (e) begin
                if (m_n == total - 1) begin
                    m_done = 1;
                    m_n    = 0;
                    if (a) begin
                        m_b0 = b0; m_b1 = b1;
                    end else begin
                        m_busy = 0;
                    end
                end else begin
                    m_n++;
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; en = 1'b0; auto_restart = 1'b0; bound = '0;
        repeat (2) @(posedge clk);

        // Reset state, then a reset with start also asserted stays idle.
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 1, 1, 0, 2, 1);
        cyc(0, 0, 1, 0, 0, 0);

        // 3x2 run with stable enable.
        cyc(0, 1, 1, 0, 2, 1);
        repeat (8) cyc(0, 0, 1, 0, 2, 1);

        // Single-iteration run.
        cyc(0, 1, 1, 0, 0, 0);
        repeat (3) cyc(0, 0, 1, 0, 0, 0);

        // Alternating enable; start held high during the run must be ignored.
        cyc(0, 1, 1, 0, 1, 2);
        for (int i = 0; i < 14; i++) cyc(0, 1, (i % 2) == 0, 0, 1, 2);
        cyc(0, 0, 0, 0, 0, 0);

        // Auto-restart with a bound change mid-run, then drop auto-restart.
        cyc(0, 1, 1, 1, 1, 1);
        repeat (2) cyc(0, 0, 1, 1, 1, 1);
        cyc(0, 0, 1, 1, 0, 3);
        repeat (3) cyc(0, 0, 1, 1, 5, 5);
        cyc(0, 0, 1, 0, 5, 5);
        repeat (2) cyc(0, 0, 1, 0, 5, 5);

        // Reset in the middle of a run.
        cyc(0, 1, 1, 0, 2, 1);
        repeat (2) cyc(0, 0, 1, 0, 2, 1);
        cyc(1, 0, 1, 0, 2, 1);
        repeat (3) cyc(0, 0, 1, 0, 2, 1);

        // Inner level at its maximum bound carries cleanly.
        cyc(0, 1, 1, 0, 1, 15);
        repeat (34) cyc(0, 0, 1, 0, 1, 15);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            cyc(($urandom_range(0, 199) == 0),
                ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 5) == 0),
                int'($urandom_range(0, 3)),
                int'($urandom_range(0, 15)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
